sdram_cmd_gen: RTL and testbench

//  SDRAM command generator; sits directly downstream of the controller FSM.

---
 rtl/sdr_pkg.sv | 47 ++++
 rtl/sdr_timer.sv | 31 +++
 rtl/sdram_cmd_gen.sv | 199 +++++++++++++++++++
 tb/tb_sdram_cmd_gen.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sdr_pkg
// Description : Shared types and pin-command encodings for the SDRAM command
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
package sdr_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_READ      = 3'd1,
        OP_WRITE     = 3'd2,
        OP_REFRESH   = 3'd3,
        OP_PRECHARGE = 3'd4,
        OP_LOAD_MODE = 3'd5
    } sdr_op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACT_WAIT = 3'd1,
        ST_RW       = 3'd2,
        ST_BURST    = 3'd3,
        ST_PRE_WAIT = 3'd4,
        ST_REF_WAIT = 3'd5,
        ST_MRS_WAIT = 3'd6
    } t_gen_state;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INH = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    // sa bit selecting auto-precharge on RD/WR and all-banks on PRE
    localparam int AP_BIT = 10;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdr_timer.sv
`default_nettype none
// ============================================================================
// Module      : sdr_timer
// Description : Loadable down-counter with zero flag; stops at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sdr_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/sdram_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : sdram_cmd_gen
// Description : Closed-page SDRAM command generator with registered pin outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_cmd_gen
    import sdr_pkg::*;
#(
    parameter int ASIZE     = 23,
    parameter int ROWSIZE   = 12,
    parameter int COLSIZE   = 8,
    parameter int BANKSIZE  = 2,
    parameter int T_RCD     = 2,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7,
    parameter int T_MRD     = 2,
    parameter int CAS_LAT   = 3,
    parameter int BURST_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [2:0]          cmd_op,
    input  logic [ASIZE-1:0]    cmd_addr,
    input  logic [ROWSIZE-1:0]  mode_val,
    output logic                cmd_ready,
    output logic                busy,
    output logic                cke,
    output logic                cs_n,
    output logic                ras_n,
    output logic                cas_n,
    output logic                we_n,
    output logic [BANKSIZE-1:0] ba,
    output logic [ROWSIZE-1:0]  sa,
    output logic                oe,
    output logic                rd_valid
);

    localparam int FIELD_W   = BANKSIZE + ROWSIZE + COLSIZE;
    localparam int RD_CYCLES = CAS_LAT + BURST_LEN;
    localparam int T_MAX     = max_of(max_of(max_of(T_RCD, T_RP), max_of(T_RFC, T_MRD)), RD_CYCLES);
    localparam int TW        = $clog2(T_MAX) + 1;

    // Counter preloads are (cycles in state - 1); ACT_WAIT spans T_RCD-1 cycles
    localparam logic [TW-1:0] LD_RCD = TW'((T_RCD > 1) ? T_RCD - 2 : 0);
    localparam logic [TW-1:0] LD_RD  = TW'(RD_CYCLES - 1);
    localparam logic [TW-1:0] LD_WR  = TW'(BURST_LEN - 1);
    localparam logic [TW-1:0] LD_RP  = TW'(T_RP - 1);
    localparam logic [TW-1:0] LD_RFC = TW'(T_RFC - 1);
    localparam logic [TW-1:0] LD_MRD = TW'(T_MRD - 1);
    localparam logic [TW-1:0] C_BL   = TW'(BURST_LEN);

    t_gen_state          r_state;
    t_gen_state          w_next_state;
    logic                r_is_write;
    logic [COLSIZE-1:0]  r_col;
    logic                w_accept;
    logic                w_tmr_load;
    logic [TW-1:0]       w_tmr_val;
    logic [TW-1:0]       w_tmr_count;
    logic                w_tmr_zero;
    logic [3:0]          w_cmd;
    logic [BANKSIZE-1:0] w_ba;
    logic [ROWSIZE-1:0]  w_sa;
    logic [ROWSIZE-1:0]  w_rw_sa;
    logic                w_oe;
    logic                w_rd;
    logic                w_ready;

    assign w_accept = cmd_valid && cmd_ready;
    assign busy     = (r_state != ST_IDLE);

    generate
        if (ASIZE > FIELD_W) begin : g_spare_addr
            logic unused_spare;
            assign unused_spare = ^cmd_addr[ASIZE-1:FIELD_W];
        end
    endgenerate

    sdr_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .count    (w_tmr_count),
        .zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state         = r_state;
        w_cmd                = CMD_NOP;
        w_ba                 = ba;
        w_sa                 = sa;
        w_rw_sa              = '0;
        w_rw_sa[COLSIZE-1:0] = r_col;
        w_rw_sa[AP_BIT]      = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_READ, OP_WRITE: begin
                            w_cmd        = CMD_ACT;
                            w_ba         = cmd_addr[COLSIZE+ROWSIZE +: BANKSIZE];
                            w_sa         = cmd_addr[COLSIZE +: ROWSIZE];
                            w_next_state = (T_RCD > 1) ? ST_ACT_WAIT : ST_RW;
                        end
                        OP_REFRESH: begin
                            w_cmd        = CMD_REF;
                            w_next_state = ST_REF_WAIT;
                        end
                        OP_PRECHARGE: begin
                            w_cmd        = CMD_PRE;
                            w_sa         = '0;
                            w_sa[AP_BIT] = 1'b1;
                            w_next_state = ST_PRE_WAIT;
                        end
                        OP_LOAD_MODE: begin
                            w_cmd        = CMD_MRS;
                            w_ba         = '0;
                            w_sa         = mode_val;
                            w_next_state = ST_MRS_WAIT;
                        end
                        default: w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_ACT_WAIT: if (w_tmr_zero) w_next_state = ST_RW;
            ST_RW: begin
                w_cmd        = r_is_write ? CMD_WR : CMD_RD;
                w_sa         = w_rw_sa;
                w_next_state = ST_BURST;
            end
            ST_BURST:    if (w_tmr_zero) w_next_state = ST_PRE_WAIT;
            ST_PRE_WAIT, ST_REF_WAIT, ST_MRS_WAIT: begin
                if (w_tmr_zero) w_next_state = ST_IDLE;
            end
            default:     w_next_state = ST_IDLE;
        endcase

        w_tmr_load = (w_next_state != r_state);
        case (w_next_state)
            ST_ACT_WAIT: w_tmr_val = LD_RCD;
            ST_BURST:    w_tmr_val = r_is_write ? LD_WR : LD_RD;
            ST_PRE_WAIT: w_tmr_val = LD_RP;
            ST_REF_WAIT: w_tmr_val = LD_RFC;
            ST_MRS_WAIT: w_tmr_val = LD_MRD;
            default:     w_tmr_val = '0;
        endcase

        // Read data occupies the last BURST_LEN cycles of the read BURST window
        w_rd    = (r_state == ST_BURST) && !r_is_write &&
                  (w_tmr_count != '0) && (w_tmr_count <= C_BL);
        w_oe    = r_is_write && ((r_state == ST_RW) || ((r_state == ST_BURST) && !w_tmr_zero));
        w_ready = (w_next_state == ST_IDLE) && !w_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_write <= 1'b0;
            r_col      <= '0;
        end else if (w_accept) begin
            r_is_write <= (cmd_op == OP_WRITE);
            r_col      <= cmd_addr[COLSIZE-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {cs_n, ras_n, cas_n, we_n} <= CMD_INH;
            cke       <= 1'b1;
            ba        <= '0;
            sa        <= '0;
            oe        <= 1'b0;
            rd_valid  <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            {cs_n, ras_n, cas_n, we_n} <= w_cmd;
            cke       <= 1'b1;
            ba        <= w_ba;
            sa        <= w_sa;
            oe        <= w_oe;
            rd_valid  <= w_rd;
            cmd_ready <= w_ready;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sdram_cmd_gen
// Description : Scoreboard bench for sdram_cmd_gen pin commands and strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_cmd_gen;

    localparam int ASIZE = 23, ROWSIZE = 12, COLSIZE = 8, BANKSIZE = 2;
    localparam int T_RCD = 2, T_RP = 2, T_RFC = 7, T_MRD = 2, CAS_LAT = 3, BURST_LEN = 8;

    localparam logic [3:0] P_INH = 4'b1111, P_NOP = 4'b0111, P_ACT = 4'b0011, P_RD = 4'b0101;
    localparam logic [3:0] P_WR  = 4'b0100, P_PRE = 4'b0010, P_REF = 4'b0001, P_MRS = 4'b0000;
    localparam logic [2:0] O_NOP = 3'd0, O_READ = 3'd1, O_WRITE = 3'd2, O_REF = 3'd3;
    localparam logic [2:0] O_PRE = 3'd4, O_MRS = 3'd5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cmd_valid = 1'b0;
    logic [2:0]          cmd_op = '0;
    logic [ASIZE-1:0]    cmd_addr = '0;
    logic [ROWSIZE-1:0]  mode_val = '0;
    logic                cmd_ready, busy, cke, cs_n, ras_n, cas_n, we_n, oe, rd_valid;
    logic [BANKSIZE-1:0] ba;
    logic [ROWSIZE-1:0]  sa;
    logic [3:0]          pins;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0]          cmd;
        logic                chk_ba;
        logic [BANKSIZE-1:0] ba;
        logic [ROWSIZE-1:0]  sa_mask;
        logic [ROWSIZE-1:0]  sa;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] v_rd, v_oe, v_rdy, v_cmd;

    assign pins = {cs_n, ras_n, cas_n, we_n};

    sdram_cmd_gen #(
        .ASIZE (ASIZE), .ROWSIZE (ROWSIZE), .COLSIZE (COLSIZE), .BANKSIZE (BANKSIZE),
        .T_RCD (T_RCD), .T_RP (T_RP), .T_RFC (T_RFC), .T_MRD (T_MRD),
        .CAS_LAT (CAS_LAT), .BURST_LEN (BURST_LEN)
    ) dut (
        .clk (clk), .rst (rst), .cmd_valid (cmd_valid), .cmd_op (cmd_op),
        .cmd_addr (cmd_addr), .mode_val (mode_val), .cmd_ready (cmd_ready),
        .busy (busy), .cke (cke), .cs_n (cs_n), .ras_n (ras_n), .cas_n (cas_n),
        .we_n (we_n), .ba (ba), .sa (sa), .oe (oe), .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    // Every non-NOP pin command is matched against the next expected entry
    always @(negedge clk) begin
        if (!rst && pins !== P_NOP && pins !== P_INH) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: pins=%b ba=%0d sa=%h, required no command", pins, ba, sa);
            end else begin
                mon_e = sb.pop_front();
                if (pins !== mon_e.cmd || (mon_e.chk_ba && ba !== mon_e.ba) ||
                    ((sa & mon_e.sa_mask) !== mon_e.sa)) begin
                    n_fail++;
                    $display("FAIL sb_cmd: pins=%b ba=%0d sa=%h, required pins=%b ba=%0d sa=%h (mask %h)",
                             pins, ba, sa, mon_e.cmd, mon_e.ba, mon_e.sa, mon_e.sa_mask);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] c, input logic chk, input logic [BANKSIZE-1:0] b,
                        input logic [ROWSIZE-1:0] m, input logic [ROWSIZE-1:0] s);
        exp_t e;
        e.cmd = c; e.chk_ba = chk; e.ba = b; e.sa_mask = m; e.sa = s;
        sb.push_back(e);
    endtask

    // Waits (bounded) for cmd_ready, then presents one op for one cycle
    task automatic issue(input logic [2:0] op, input logic [ASIZE-1:0] addr,
                         input logic [ROWSIZE-1:0] mv, output int waited);
        waited = 0;
        while (cmd_ready !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, waited);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; mode_val = mv;
        tick();
        cmd_valid = 1'b0; cmd_op = O_NOP;
        cmd_addr  = ASIZE'($urandom);
        mode_val  = ROWSIZE'($urandom);
    endtask

    task automatic capture(input int n);
        v_rd = '0; v_oe = '0; v_rdy = '0; v_cmd = '0;
        for (int t = 1; t < n; t++) begin
            v_rd[t]  = rd_valid;
            v_oe[t]  = oe;
            v_rdy[t] = cmd_ready;
            v_cmd[t] = (pins !== P_NOP);
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({pins, cke, ba, sa, oe, rd_valid, cmd_ready, busy} !== {P_INH, 1'b1, 2'd0, 12'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_values: pins=%b cke=%b ba=%0d sa=%h oe=%b rdv=%b rdy=%b busy=%b, required 1111 1 0 000 0 0 0 0",
                     pins, cke, ba, sa, oe, rd_valid, cmd_ready, busy);
        end
        rst = 1'b0;
        tick();
        n_tests++;
        if (cmd_ready !== 1'b1 || pins !== P_NOP || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b pins=%b busy=%b, required rdy=1 pins=0111 busy=0", cmd_ready, pins, busy);
        end
    endtask

    task automatic run_read(input logic [1:0] bank, input logic [11:0] row, input logic [7:0] col);
        int w;
        logic [31:0] e_rd, e_rdy, e_cmd;
        push(P_ACT, 1'b1, bank, 12'hFFF, row);
        push(P_RD,  1'b1, bank, 12'hFFF, 12'h400 | {4'h0, col});
        issue(O_READ, {1'b0, bank, row, col}, 12'h000, w);
        capture(32);
        e_cmd = '0; e_rd = '0; e_rdy = '0;
        e_cmd[1] = 1'b1;
        e_cmd[1 + T_RCD] = 1'b1;
        for (int t = 1 + T_RCD + CAS_LAT; t < 1 + T_RCD + CAS_LAT + BURST_LEN; t++) e_rd[t] = 1'b1;
        for (int t = 1 + T_RCD + CAS_LAT + BURST_LEN + T_RP; t < 32; t++) e_rdy[t] = 1'b1;
        n_tests++;
        if (v_cmd !== e_cmd) begin
            n_fail++;
            $display("FAIL read_cmd_timing: cycles=%h, required %h", v_cmd, e_cmd);
        end
        n_tests++;
        if (v_rd !== e_rd) begin
            n_fail++;
            $display("FAIL read_rd_valid: cycles=%h, required %h", v_rd, e_rd);
        end
        n_tests++;
        if (v_oe !== 32'h0) begin
            n_fail++;
            $display("FAIL read_oe: cycles=%h, required 00000000", v_oe);
        end
        n_tests++;
        if (v_rdy !== e_rdy) begin
            n_fail++;
            $display("FAIL read_ready: cycles=%h, required %h", v_rdy, e_rdy);
        end
    endtask

    task automatic test_read();
        run_read(2'd1, 12'hACF, 8'h45);
    endtask

    task automatic test_write();
        int w;
        logic [31:0] e_oe, e_rdy;
        push(P_ACT, 1'b1, 2'd2, 12'hFFF, 12'h123);
        push(P_WR,  1'b1, 2'd2, 12'hFFF, 12'h4FF);
        issue(O_WRITE, {1'b0, 2'd2, 12'h123, 8'hFF}, 12'h000, w);
        capture(32);
        e_oe = '0; e_rdy = '0;
        for (int t = 1 + T_RCD; t < 1 + T_RCD + BURST_LEN; t++) e_oe[t] = 1'b1;
        for (int t = 1 + T_RCD + BURST_LEN + T_RP; t < 32; t++) e_rdy[t] = 1'b1;
        n_tests++;
        if (v_oe !== e_oe) begin
            n_fail++;
            $display("FAIL write_oe: cycles=%h, required %h", v_oe, e_oe);
        end
        n_tests++;
        if (v_rd !== 32'h0) begin
            n_fail++;
            $display("FAIL write_rd_valid: cycles=%h, required 00000000", v_rd);
        end
        n_tests++;
        if (v_rdy !== e_rdy) begin
            n_fail++;
            $display("FAIL write_ready: cycles=%h, required %h", v_rdy, e_rdy);
        end
    endtask

    task automatic test_refresh_precharge();
        int w;
        push(P_REF, 1'b0, 2'd0, 12'h000, 12'h000);
        issue(O_REF, '0, 12'h000, w);
        n_tests++;
        if (pins !== P_REF) begin
            n_fail++;
            $display("FAIL refresh_pins: pins=%b, required %b", pins, P_REF);
        end
        push(P_PRE, 1'b0, 2'd0, 12'h400, 12'h400);
        issue(O_PRE, '0, 12'h000, w);
        n_tests++;
        if (w < T_RFC || w > T_RFC + 1) begin
            n_fail++;
            $display("FAIL refresh_gap: accept after %0d cycles, required %0d..%0d", w, T_RFC, T_RFC + 1);
        end
        n_tests++;
        if (pins !== P_PRE || sa[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL precharge_pins: pins=%b sa=%h, required pins=%b sa[10]=1", pins, sa, P_PRE);
        end
    endtask

    task automatic test_load_mode();
        int w;
        int low;
        push(P_MRS, 1'b1, 2'd0, 12'hFFF, 12'h033);
        issue(O_MRS, {1'b0, 2'd3, 12'hFFF, 8'hFF}, 12'h033, w);
        low = 0;
        while (cmd_ready !== 1'b1 && low < 20) begin
            low++;
            tick();
        end
        n_tests++;
        if (low < T_MRD || low > T_MRD + 1) begin
            n_fail++;
            $display("FAIL mrs_ready_low: low for %0d cycles, required %0d..%0d", low, T_MRD, T_MRD + 1);
        end
    endtask

    task automatic test_nop_ops();
        logic [2:0] ops [3];
        int w;
        ops[0] = O_NOP; ops[1] = 3'd6; ops[2] = 3'd7;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], '1, 12'hFFF, w);
            n_tests++;
            if (cmd_ready !== 1'b0 || pins !== P_NOP || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL nop_op%0d_accept: rdy=%b pins=%b busy=%b, required 0 0111 0", ops[i], cmd_ready, pins, busy);
            end
            tick();
            n_tests++;
            if (cmd_ready !== 1'b1 || pins !== P_NOP) begin
                n_fail++;
                $display("FAIL nop_op%0d_return: rdy=%b pins=%b, required 1 0111", ops[i], cmd_ready, pins);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int w;
        int ncmd;
        push(P_ACT, 1'b1, 2'd0, 12'hFFF, 12'h055);
        push(P_WR,  1'b1, 2'd0, 12'hFFF, 12'h4AA);
        issue(O_WRITE, {1'b0, 2'd0, 12'h055, 8'hAA}, 12'h000, w);
        ncmd = 0;
        for (int t = 1; t < 26; t++) begin
            cmd_valid = (t <= 5);
            cmd_op    = O_REF;
            if (pins !== P_NOP) ncmd++;
            tick();
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (ncmd != 2) begin
            n_fail++;
            $display("FAIL ignore_busy: %0d pin commands, required 2", ncmd);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        int k;
        logic [2:0] op;
        for (int i = 0; i < 2; i++) begin
            op = (i == 0) ? O_WRITE : O_READ;
            push(P_ACT, 1'b1, 2'd3, 12'hFFF, 12'h0F0);
            push((i == 0) ? P_WR : P_RD, 1'b1, 2'd3, 12'hFFF, 12'h411);
            issue(op, {1'b0, 2'd3, 12'h0F0, 8'h11}, 12'h000, w);
            k = 0;
            while (((i == 0) ? oe : rd_valid) !== 1'b1 && k < 20) begin
                tick();
                k++;
            end
            tick();
            n_tests++;
            if (((i == 0) ? oe : rd_valid) !== 1'b1) begin
                n_fail++;
                $display("FAIL midrst_op%0d_strobe: strobe=0, required 1 before reset", op);
            end
            #3;
            rst = 1'b1;
            #1;
            n_tests++;
            if (rd_valid !== 1'b0 || oe !== 1'b0 || pins !== P_INH || cmd_ready !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_op%0d_outputs: rdv=%b oe=%b pins=%b rdy=%b busy=%b, required 0 0 1111 0 0",
                         op, rd_valid, oe, pins, cmd_ready, busy);
            end
            n_tests++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL midrst_op%0d_pending: %0d commands pending, required 0", op, sb.size());
            end
            sb.delete();
            @(posedge clk);
            #1;
            rst = 1'b0;
            tick();
        end
        run_read(2'd3, 12'hFFF, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_refresh_precharge();
        test_load_mode();
        test_nop_ops();
        test_ignore_busy();
        test_reset_mid();
        repeat (4) tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expected commands never seen, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
